shift_deser: RTL and testbench

SHIFT_DESER -- requirements
Module: shift_deser

---
 rtl/shift_deser.sv | 101 ++++++++++
 tb/tb_shift_deser.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/shift_deser.sv
// Serial-to-parallel deserializer with valid/ready output and sticky overrun.
// Bits arrive one per SV cycle. FS marks bit 0 of a new word and latches the
// bit order from DIR. A completed word is offered on Q with DV until the
// consumer takes it with DR.
// Ports:
//   CK  - clock, rising edge
//   RST - synchronous active-high reset
//   SI  - serial data bit, SV - SI valid, FS - frame start (qualified by SV)
//   DIR - bit order sampled on an accepted FS (0 = LSB first, 1 = MSB first)
//   Q   - assembled word, DV - Q holds an unconsumed word, DR - consumer ready
//   OVR - sticky overrun: a word completed while the previous one was unconsumed
module shift_deser #(
  parameter int unsigned C_NUM_BITS = 4
) (
  input  logic                  CK,
  input  logic                  RST,
  input  logic                  SI,
  input  logic                  SV,
  input  logic                  FS,
  input  logic                  DIR,
  input  logic                  DR,
  output logic [C_NUM_BITS-1:0] Q,
  output logic                  DV,
  output logic                  OVR
);

  localparam int unsigned CW = $clog2(C_NUM_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(C_NUM_BITS);

  typedef enum logic {IDLE, RECV} state_t;

  state_t                  state, state_nx;
  logic [C_NUM_BITS-1:0]   sr, sr_nx, shifted, q_nx;
  logic [CW-1:0]           cnt, cnt_nx, bit_cnt;
  logic                    ord, ord_nx, ord_use;
  logic                    dv_nx, ovr_nx;
  logic                    start, cont, done;

  // Next-state, datapath and output-register inputs
  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    cnt_nx   = cnt;
    ord_nx   = ord;
    q_nx     = Q;
    dv_nx    = DV;
    ovr_nx   = OVR;

    // FS in either state starts a new word; in RECV it abandons the partial one
    start   = SV && FS;
    cont    = SV && !FS && (state == RECV);
    ord_use = start ? DIR : ord;
    shifted = ord_use ? {sr[C_NUM_BITS-2:0], SI} : {SI, sr[C_NUM_BITS-1:1]};
    bit_cnt = start ? CW'(1) : cnt + CW'(1);
    done    = (start || cont) && (bit_cnt == CNT_LAST);

    if (start || cont) begin
      sr_nx  = shifted;
      ord_nx = ord_use;
      if (done) begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end else begin
        cnt_nx   = bit_cnt;
        state_nx = RECV;
      end
    end

    // Output handshake: a completing word replaces a word being consumed this cycle
    if (done && (!DV || DR)) begin
      q_nx  = shifted;
      dv_nx = 1'b1;
    end else if (done) begin
      ovr_nx = 1'b1;
    end else if (DV && DR) begin
      dv_nx = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge CK) begin
    if (RST) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      ord   <= 1'b0;
      Q     <= '0;
      DV    <= 1'b0;
      OVR   <= 1'b0;
    end else begin
      state <= state_nx;
      sr    <= sr_nx;
      cnt   <= cnt_nx;
      ord   <= ord_nx;
      Q     <= q_nx;
      DV    <= dv_nx;
      OVR   <= ovr_nx;
    end
  end

endmodule

// File: tb/tb_shift_deser.sv
// Scoreboard bench for shift_deser (C_NUM_BITS=4): stimulus pushes expected
// words, a negedge monitor pops and compares on every DV&DR transfer.
module tb_shift_deser;

  logic       CK = 1'b0;
  logic       RST = 1'b1;
  logic       SI = 1'b0;
  logic       SV = 1'b0;
  logic       FS = 1'b0;
  logic       DIR = 1'b0;
  logic       DR = 1'b0;
  logic [3:0] Q;
  logic       DV;
  logic       OVR;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];

  shift_deser #(.C_NUM_BITS(4)) dut (
    .CK(CK), .RST(RST), .SI(SI), .SV(SV), .FS(FS), .DIR(DIR),
    .DR(DR), .Q(Q), .DV(DV), .OVR(OVR)
  );

  always #5 CK = ~CK;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every transfer must match the oldest expected word
  always @(negedge CK) begin
    if (!RST && DV && DR) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL xfer_unexpected: got %h required no transfer at %0t", Q, $time);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (Q !== e) begin
          failures++;
          $display("FAIL xfer_q: got %h required %h at %0t", Q, e, $time);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CK);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic f, input logic d);
    SV = 1'b1; SI = b; FS = f; DIR = d;
    @(posedge CK);
    #1;
    SV = 1'b0; SI = 1'b0; FS = 1'b0;
  endtask

  // Four bits in arrival order, FS on the first, optional idle gap after each
  task automatic send_seq(input logic b0, input logic b1, input logic b2, input logic b3,
                          input logic d, input int gap);
    send_bit(b0, 1'b1, d); if (gap > 0) idle(gap);
    send_bit(b1, 1'b0, d); if (gap > 0) idle(gap);
    send_bit(b2, 1'b0, d); if (gap > 0) idle(gap);
    send_bit(b3, 1'b0, d);
  endtask

  initial begin
    idle(2);
    check("rst_q", Q, 4'h0);
    check("rst_dv", {3'b0, DV}, 4'h0);
    check("rst_ovr", {3'b0, OVR}, 4'h0);
    RST = 1'b0;
    DR = 1'b1;
    idle(1);

    // LSB first 1,0,1,1 -> 1101, DV one cycle after the last bit
    exp_q.push_back(4'b1101);
    send_seq(1, 0, 1, 1, 1'b0, 0);
    check("lsb_dv_latency", {3'b0, DV}, 4'h1);
    idle(2);
    check("lsb_dv_cleared", {3'b0, DV}, 4'h0);

    // MSB first 1,0,1,1 -> 1011, back-to-back and with gaps
    exp_q.push_back(4'b1011);
    send_seq(1, 0, 1, 1, 1'b1, 0);
    idle(2);
    exp_q.push_back(4'b1011);
    send_seq(1, 0, 1, 1, 1'b1, 2);
    idle(2);

    // Back-to-back words 3 and C with DR held
    exp_q.push_back(4'h3);
    exp_q.push_back(4'hC);
    send_seq(1, 1, 0, 0, 1'b0, 0);
    send_seq(0, 0, 1, 1, 1'b0, 0);
    idle(2);
    check("b2b_ovr", {3'b0, OVR}, 4'h0);

    // Abort after 2 bits, only the new word 6 appears
    exp_q.push_back(4'h6);
    send_bit(1, 1'b1, 1'b0);
    send_bit(1, 1'b0, 1'b0);
    send_seq(0, 1, 1, 0, 1'b0, 0);
    idle(2);

    // Overrun: A then 5 with DR low
    DR = 1'b0;
    exp_q.push_back(4'hA);
    send_seq(0, 1, 0, 1, 1'b0, 0);
    send_seq(1, 0, 1, 0, 1'b0, 0);
    idle(1);
    check("ovr_q_hold", Q, 4'hA);
    check("ovr_dv", {3'b0, DV}, 4'h1);
    check("ovr_flag", {3'b0, OVR}, 4'h1);
    DR = 1'b1;
    idle(1);
    DR = 1'b0;
    check("ovr_dv_cleared", {3'b0, DV}, 4'h0);
    check("ovr_sticky", {3'b0, OVR}, 4'h1);

    // Reset mid-frame with a pending word and OVR set
    send_seq(1, 0, 0, 1, 1'b0, 0);
    send_bit(1, 1'b1, 1'b0);
    send_bit(0, 1'b0, 1'b0);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    check("rst_mid_q", Q, 4'h0);
    check("rst_mid_dv", {3'b0, DV}, 4'h0);
    check("rst_mid_ovr", {3'b0, OVR}, 4'h0);

    // Full frame after reset: MSB first 1,1,1,0 -> E
    DR = 1'b1;
    exp_q.push_back(4'hE);
    send_seq(1, 1, 1, 0, 1'b1, 0);
    idle(3);
    check("queue_drained", 4'(exp_q.size()), 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
